// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR/PRBS blocks: checker lock states,
// standard PRBS feedback polynomials and a bit-count helper.
package lfsr_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  // Feedback polynomials, bit j set for each x^j term (x^0 implied by bit 0)
  localparam logic [6:0]  PRBS7  = 7'h41;        // x^7  + x^6  + 1
  localparam logic [8:0]  PRBS9  = 9'h021;       // x^9  + x^5  + 1
  localparam logic [14:0] PRBS15 = 15'h4001;     // x^15 + x^14 + 1
  localparam logic [22:0] PRBS23 = 23'h040001;   // x^23 + x^18 + 1
  localparam logic [30:0] PRBS31 = 31'h10000001; // x^31 + x^28 + 1

  // Widest vector popcount accepts; narrower callers zero-extend
  localparam int unsigned POPCOUNT_MAX = 64;

  function automatic int unsigned popcount(input logic [POPCOUNT_MAX-1:0] value);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POPCOUNT_MAX; i++) begin
      if (value[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational multi-bit LFSR step. Processes DATA_WIDTH input bits per
// call (MSB first unless REVERSE) in Fibonacci or Galois form. With
// LFSR_FEED_FORWARD the register shifts in the data bits themselves,
// which turns the block into a self-synchronising descrambler/checker.
module lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");

  logic [LFSR_WIDTH-1:0] s;
  logic                  fb;
  logic                  d;
  int unsigned           idx;

  // Unrolled bit-serial LFSR: one shift per data bit
  always_comb begin
    s        = state_in;
    data_out = '0;
    fb       = 1'b0;
    d        = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      idx = REVERSE ? k : (DATA_WIDTH - 1 - k);
      d   = data_in[idx];
      if (IS_GALOIS) begin
        fb = s[LFSR_WIDTH-1] ^ d;
        s  = {s[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD ? d : fb)}
             ^ ({LFSR_WIDTH{fb}} & {LFSR_POLY[LFSR_WIDTH-1:1], 1'b0});
      end else begin
        fb = s[LFSR_WIDTH-1] ^ (^(s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1])) ^ d;
        s  = {s[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD ? d : fb)};
      end
      data_out[idx] = fb;
    end
    state_out = s;
  end

endmodule

// File: rtl/lfsr_prbs_check.sv
// PRBS checker: feed-forward descrambler that self-synchronises to the
// received stream, a HUNT/LOCKED link-health FSM, and saturating word,
// error-word and bit-error counters for BER measurement.
module lfsr_prbs_check
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH    = 9,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = PRBS9,
  parameter bit                    REVERSE       = 1'b0,
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    UNLOCK_ERRORS = 4,
  parameter int                    COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  input_tdata,
  input  logic                   input_tvalid,
  input  logic                   clear_counts,
  output logic                   locked,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [COUNT_WIDTH-1:0] error_word_count,
  output logic [COUNT_WIDTH-1:0] bit_error_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRORS + 1);
  localparam int PC_W   = $clog2(DATA_WIDTH + 1);

  prbs_state_t           fsm_state;
  logic [LFSR_WIDTH-1:0] state_reg;
  logic [LFSR_WIDTH-1:0] state_next;
  logic [DATA_WIDTH-1:0] mismatch;
  logic [GOOD_W-1:0]     good_cnt;
  logic [GOOD_W-1:0]     good_inc;
  logic [BAD_W-1:0]      bad_cnt;
  logic [BAD_W-1:0]      bad_inc;
  logic                  good_full;
  logic                  bad_full;
  logic                  word_bad;
  logic                  word_clean;
  logic [PC_W-1:0]       bit_errs;

  function automatic logic [COUNT_WIDTH-1:0] sat_add(
    input logic [COUNT_WIDTH-1:0] a,
    input logic [PC_W-1:0]        inc
  );
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + (COUNT_WIDTH+1)'(inc);
    return sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
  endfunction

  lfsr #(
    .LFSR_WIDTH        (LFSR_WIDTH),
    .LFSR_POLY         (LFSR_POLY),
    .LFSR_CONFIG       ("FIBONACCI"),
    .LFSR_FEED_FORWARD (1'b1),
    .REVERSE           (REVERSE),
    .DATA_WIDTH        (DATA_WIDTH)
  ) descrambler (
    .data_in   (input_tdata),
    .state_in  (state_reg),
    .data_out  (mismatch),
    .state_out (state_next)
  );

  // An all-zero descrambler state predicts nothing, so such a word is never clean
  assign word_bad   = |mismatch;
  assign word_clean = !word_bad && (|state_next);
  assign good_inc   = good_cnt + GOOD_W'(1);
  assign bad_inc    = bad_cnt + BAD_W'(1);
  assign good_full  = (good_inc == GOOD_W'(LOCK_COUNT));
  assign bad_full   = (bad_inc == BAD_W'(UNLOCK_ERRORS));
  assign bit_errs   = PC_W'(popcount(POPCOUNT_MAX'(mismatch)));

  // Descrambler history advances only on accepted words
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= '1;
    end else if (input_tvalid) begin
      state_reg <= state_next;
    end
  end

  // Lock FSM with run counters; locked and error are registered alongside
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_state <= HUNT;
      locked    <= 1'b0;
      error     <= 1'b0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      error <= input_tvalid && word_bad;
      if (input_tvalid) begin
        unique case (fsm_state)
          HUNT: begin
            if (word_clean) begin
              if (good_full) begin
                fsm_state <= LOCKED;
                locked    <= 1'b1;
                good_cnt  <= '0;
                bad_cnt   <= '0;
              end else begin
                good_cnt <= good_inc;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (word_bad) begin
              good_cnt <= '0;
              if (bad_full) begin
                fsm_state <= HUNT;
                locked    <= 1'b0;
                bad_cnt   <= '0;
              end else begin
                bad_cnt <= bad_inc;
              end
            end else if (word_clean) begin
              if (good_full) begin
                good_cnt <= '0;
                bad_cnt  <= '0;
              end else begin
                good_cnt <= good_inc;
              end
            end else begin
              good_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

  // Statistics: counted while locked (including the word that drops lock), clear wins
  always_ff @(posedge clk) begin
    if (!rst || clear_counts) begin
      word_count       <= '0;
      error_word_count <= '0;
      bit_error_count  <= '0;
    end else if (input_tvalid && fsm_state == LOCKED) begin
      word_count       <= sat_add(word_count, PC_W'(1));
      error_word_count <= sat_add(error_word_count, PC_W'(word_bad));
      bit_error_count  <= sat_add(bit_error_count, bit_errs);
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Bench for lfsr_prbs_check: a bit-history PRBS9 model predicts every
// output each cycle for a 32-bit-counter and a 4-bit-counter instance.
`timescale 1ns/1ps
module tb_lfsr_prbs_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  input_tdata = '0;
  logic        input_tvalid = 1'b0;
  logic        clear_counts = 1'b0;
  logic        locked, error, locked4, error4;
  logic [31:0] word_count, error_word_count, bit_error_count;
  logic [3:0]  wc4, ewc4, bec4;

  always #5 clk = ~clk;

  lfsr_prbs_check dut (
    .clk(clk), .rst(rst), .input_tdata(input_tdata), .input_tvalid(input_tvalid),
    .clear_counts(clear_counts), .locked(locked), .error(error),
    .word_count(word_count), .error_word_count(error_word_count),
    .bit_error_count(bit_error_count)
  );

  lfsr_prbs_check #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .input_tdata(input_tdata), .input_tvalid(input_tvalid),
    .clear_counts(clear_counts), .locked(locked4), .error(error4),
    .word_count(wc4), .error_word_count(ewc4), .bit_error_count(bec4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: received-bit history (oldest first) and expected outputs
  bit rx_hist[$];
  bit gen_hist[$];
  bit m_locked, m_error;
  int m_good, m_badw;
  longint unsigned m_wc, m_ewc, m_bec, m4_wc, m4_ewc, m4_bec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned v, input int unsigned inc, input int w);
    longint unsigned lim;
    lim = (64'd1 << w) - 1;
    return (v + inc > lim) ? lim : v + inc;
  endfunction

  // PRBS9 source: g[n] = g[n-9] ^ g[n-5], MSB of each word first
  function automatic logic [7:0] gen_word();
    logic [7:0] w;
    bit g;
    for (int i = 7; i >= 0; i--) begin
      g = gen_hist[0] ^ gen_hist[4];
      w[i] = g;
      void'(gen_hist.pop_front());
      gen_hist.push_back(g);
    end
    return w;
  endfunction

  task automatic model_reset();
    rx_hist.delete();
    repeat (9) rx_hist.push_back(1'b1);
    m_locked = 0; m_error = 0; m_good = 0; m_badw = 0;
    m_wc = 0; m_ewc = 0; m_bec = 0; m4_wc = 0; m4_ewc = 0; m4_bec = 0;
  endtask

  task automatic model_clear(input bit clr);
    if (clr) begin
      m_wc = 0; m_ewc = 0; m_bec = 0; m4_wc = 0; m4_ewc = 0; m4_bec = 0;
    end
  endtask

  task automatic model_word(input logic [7:0] d, input bit clr);
    logic [7:0] mis;
    bit nz, bad, clean;
    int pc;
    for (int i = 7; i >= 0; i--) begin
      mis[i] = d[i] ^ rx_hist[4] ^ rx_hist[0];
      void'(rx_hist.pop_front());
      rx_hist.push_back(d[i]);
    end
    nz = 0;
    foreach (rx_hist[k]) nz |= rx_hist[k];
    bad   = (mis != 0);
    clean = !bad && nz;
    pc    = $countones(mis);
    if (m_locked) begin
      m_wc  = sat(m_wc, 1, 32);  m_ewc  = sat(m_ewc, bad, 32);  m_bec  = sat(m_bec, pc, 32);
      m4_wc = sat(m4_wc, 1, 4);  m4_ewc = sat(m4_ewc, bad, 4);  m4_bec = sat(m4_bec, pc, 4);
    end
    if (!m_locked) begin
      if (clean) begin
        m_good++;
        if (m_good == 16) begin m_locked = 1; m_good = 0; m_badw = 0; end
      end else m_good = 0;
    end else if (bad) begin
      m_badw++; m_good = 0;
      if (m_badw == 4) begin m_locked = 0; m_badw = 0; end
    end else if (clean) begin
      m_good++;
      if (m_good == 16) begin m_good = 0; m_badw = 0; end
    end else m_good = 0;
    m_error = bad;
    model_clear(clr);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit clr);
    input_tvalid = v; input_tdata = d; clear_counts = clr;
    @(posedge clk);
    if (v) model_word(d, clr);
    else begin m_error = 0; model_clear(clr); end
    #1;
  endtask

  task automatic do_reset();
    rst = 0; input_tvalid = 0; clear_counts = 0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1; chk_en = 1;
  endtask

  task automatic clean_words(input int n);
    repeat (n) step(1, gen_word(), 0);
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("locked", locked, m_locked);
      check("error", error, m_error);
      check("word_count", word_count, m_wc);
      check("error_word_count", error_word_count, m_ewc);
      check("bit_error_count", bit_error_count, m_bec);
      check("locked_w4", locked4, m_locked);
      check("word_count_w4", wc4, m4_wc);
      check("error_word_count_w4", ewc4, m4_ewc);
      check("bit_error_count_w4", bec4, m4_bec);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    longint unsigned bec0, ewc0, wc0, dlt;
    int n, ever, errs;

    gen_hist.delete();
    repeat (9) gen_hist.push_back(1'b1);
    model_reset();
    #2;
    do_reset();
    check("reset_locked", locked, 0);
    check("reset_word_count", word_count, 0);

    // 1: lock on aligned PRBS9 (seed all-ones, checker history all-ones)
    n = 0;
    for (int k = 0; k < 40 && !locked; k++) begin
      w = gen_word();
      if (k == 0) check("gen_pin_word0", w, 8'h07);
      if (k == 1) check("gen_pin_word1", w, 8'hBE);
      step(1, w, 0);
      n++;
    end
    check("lock_words", n, 16);
    clean_words(20);
    check("clean_word_count", word_count, 20);
    check("clean_error_words", error_word_count, 0);

    // 2: single-bit flip while locked
    bec0 = m_bec; ewc0 = m_ewc;
    step(1, gen_word() ^ 8'h08, 0);
    clean_words(6);
    check("flip_bec_delta", bit_error_count - bec0, 3);
    dlt = error_word_count - ewc0;
    check("flip_ewc_delta_2_or_3", (dlt == 2 || dlt == 3), 1);
    check("flip_locked", locked, 1);
    clean_words(30);

    // 3: four inverted words drop lock; the fourth is still counted
    wc0 = m_wc;
    for (int i = 0; i < 4; i++) begin
      step(1, ~gen_word(), 0);
      if (i == 2) check("inv_locked_after3", locked, 1);
    end
    check("inv_unlock_after4", locked, 0);
    check("inv_4th_counted", word_count - wc0, 4);
    clean_words(10);
    check("freeze_word_count", word_count, wc0 + 4);
    for (int k = 0; k < 60 && !locked; k++) step(1, gen_word(), 0);
    check("relocked", locked, 1);

    // 5: clear beats a same-cycle bad word; 4-bit counters saturate
    clean_words(20);
    step(1, gen_word() ^ 8'h10, 1);
    check("clear_wc", word_count, 0);
    check("clear_ewc", error_word_count, 0);
    check("clear_bec", bit_error_count, 0);
    check("clear_ewc_w4", ewc4, 0);
    clean_words(20);
    for (int r = 0; r < 10; r++) begin
      step(1, gen_word() ^ 8'h08, 0);
      clean_words(20);
    end
    check("sat_ewc32_ge20", error_word_count >= 20, 1);
    check("sat_ewc_w4", ewc4, 4'hF);
    check("sat_wc_w4", wc4, 4'hF);
    check("sat_bec_w4", bec4, 4'hF);
    check("sat_still_locked", locked, 1);

    // 4: constant 0x00 never locks; constant 0xFF errors on every word
    do_reset();
    ever = 0;
    repeat (100) begin step(1, 8'h00, 0); ever |= locked; end
    check("zeros_never_locked", ever, 0);
    check("zeros_word_count", word_count, 0);
    check("zeros_bec", bit_error_count, 0);
    do_reset();
    ever = 0; errs = 0;
    repeat (100) begin step(1, 8'hFF, 0); ever |= locked; errs += error; end
    check("ones_never_locked", ever, 0);
    check("ones_error_pulses", errs, 100);

    // 6: reset while locked, then re-hunt with tvalid gaps
    do_reset();
    for (int k = 0; k < 60 && !locked; k++) step(1, gen_word(), 0);
    check("pre_reset_locked", locked, 1);
    clean_words(5);
    do_reset();
    check("mid_reset_locked", locked, 0);
    check("mid_reset_error", error, 0);
    check("mid_reset_wc", word_count, 0);
    check("mid_reset_ewc", error_word_count, 0);
    check("mid_reset_bec", bit_error_count, 0);
    n = 0;
    for (int k = 0; k < 200 && !locked; k++) begin
      if (k % 3 == 1) step(0, 8'hA5, 0);
      else begin step(1, gen_word(), 0); n++; end
    end
    check("gap_relock_words_16_to_18", (n >= 16 && n <= 18), 1);
    clean_words(4);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs_check.md
# lfsr_prbs_check

PRBS checker: the receive-side counterpart of the `lfsr`-based PRBS generator. It accepts a stream of DATA_WIDTH-bit words and self-synchronises a feed-forward LFSR descrambler to the incoming sequence. A lock state machine tracks link health, and saturating word, error-word and bit-error counters support link BER measurement. It sits after the deserializer or loopback path, and its outputs feed status registers.

## Interface
- LFSR_WIDTH, 9: LFSR length.
- LFSR_POLY, 9'h021: feedback polynomial (PRBS9, x^9+x^5+1).
- REVERSE, 0: bit order; passed to `lfsr`.
- DATA_WIDTH, 8: input word width.
- LOCK_COUNT, 16: consecutive clean words needed to lock; also clears the bad-word count while locked.
- UNLOCK_ERRORS, 4: bad words (without an intervening clean run of LOCK_COUNT) that drop lock.
- COUNT_WIDTH, 32: width of each statistics counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset; synchronous, active-low.
- input_tdata, input, DATA_WIDTH: received PRBS word.
- input_tvalid, input, 1: word qualifier. There is no backpressure; the block is always ready.
- clear_counts, input, 1: synchronous clear of all three counters.
- locked, output, 1: the checker is in the LOCKED state.
- error, output, 1: one-cycle pulse for an accepted word with a nonzero mismatch.
- word_count, output, COUNT_WIDTH: words accepted while locked.
- error_word_count, output, COUNT_WIDTH: bad words accepted while locked.
- bit_error_count, output, COUNT_WIDTH: mismatched bits accepted while locked.

## Operation
- Descrambler
  - `lfsr` runs in FIBONACCI mode with FEED_FORWARD=1, data_in = input_tdata, state_in = state_reg.
  - On each valid word, state_reg <= state_out.
  - mismatch = data_out. Bits set in mismatch are bit errors.
  - A word is bad if mismatch != 0. It is clean if mismatch == 0 and state_out != 0.
  - An all-zero stream is therefore never clean.
- Self-synchronisation
  - The descrambler state is a function of the last LFSR_WIDTH input bits.
  - It is correct after ceil(LFSR_WIDTH/DATA_WIDTH) words; that is 2 words at the defaults.
- FSM states: HUNT (reset state) and LOCKED.
  - In HUNT, a clean word does good_cnt++. A bad word sets good_cnt <= 0.
  - In HUNT, when good_cnt reaches LOCK_COUNT, go to LOCKED, then good_cnt <= 0 and bad_cnt <= 0.
  - In LOCKED, a bad word does bad_cnt++ and good_cnt <= 0.
  - In LOCKED, a clean word does good_cnt++. When good_cnt reaches LOCK_COUNT, bad_cnt <= 0 and good_cnt <= 0.
  - In LOCKED, when bad_cnt reaches UNLOCK_ERRORS, go to HUNT with both counts at 0.
  - The word that drops lock is still counted.
- Counters
  - Counters update only for valid words while in LOCKED, including the word that drops lock.
  - word_count += 1.
  - error_word_count += (mismatch != 0).
  - bit_error_count += popcount(mismatch). The popcount width is $clog2(DATA_WIDTH+1), zero-extended before the add.
  - All counters saturate at all-ones and never wrap.
  - clear_counts has priority over any increment in the same cycle: the counters read 0 next cycle and that cycle's increments are dropped.
- error pulses for bad words in either state.
- While input_tvalid=0, nothing changes: state_reg, the FSM, the counters and error (0) all hold.

## Timing
- All outputs are registered. An accepted word on cycle N is reflected in error, locked and the counters on cycle N+1.
- Lock asserts on the cycle after the LOCK_COUNT-th consecutive clean word.
- Reset (rst=0 at a clock edge) takes effect on the next cycle. Reset values:
  - locked = 0, error = 0, all counters 0.
  - state_reg all-ones, good_cnt = 0, bad_cnt = 0, FSM in HUNT.
- Reset mid-stream discards lock. The checker re-hunts from the next valid word.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package `lfsr_pkg` holds:
  - the FSM state typedef (HUNT, LOCKED);
  - the PRBS polynomial constants PRBS7/9/15/23/31 (e.g. PRBS9 = 9'h021);
  - a popcount function.
- Sub-module: exactly one instance of the existing `lfsr` as the combinational descrambler. Everything else is in-line.
- Target size is 150-250 lines of RTL.

## Test plan
1. Lock on clean PRBS9: drive PRBS9 from a `lfsr` generator (seed 9'h1FF) with tvalid always high. Required: locked rises no later than LOCK_COUNT+2 words after the first valid word; error_word_count = 0; word_count tracks accepted words.
2. Single-bit flip while locked. Required: bit_error_count += 3 (the bit plus two tap echoes), error_word_count += 2 or 3, locked stays 1.
3. Invert 4 consecutive words while locked. Required: locked falls the cycle after the 4th; that word is counted; counters freeze afterwards; re-lock occurs after a clean run.
4. Constant 0x00 input for 100 words. Required: locked never asserts and all counters stay 0. Repeat with 0xFF input: error pulses on every word, locked stays 0.
5. clear_counts asserted on the same cycle as a bad word while locked. Required: all counters read 0 next cycle. With COUNT_WIDTH=4, 20 bad words give error_word_count = 4'hF, held with no wrap.
6. Reset mid-stream while locked, with tvalid gaps inserted. Required: all outputs reach their reset values next cycle, and re-lock timing is unaffected by the gaps.
